// File: rtl/sisc_pkg.sv
// Encodings and types shared by the PC sequencer and the control unit.
package sisc_pkg;

  typedef enum logic [1:0] {
    PCM_INC  = 2'b00,
    PCM_BR   = 2'b01,
    PCM_CALL = 2'b10,
    PCM_RET  = 2'b11
  } pc_mode_e;

endpackage : sisc_pkg

// File: rtl/ret_stack.sv
// Return-address LIFO. Only the entry counter is reset; only entries below cnt are ever read.
module ret_stack #(
  parameter int AW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [AW-1:0]            din,
  output logic [AW-1:0]            top,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] IDX_ONE = PW'(1);
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW:0]   cnt_q, cnt_d;
  logic [PW-1:0] top_idx;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CNT_MAX);
  assign empty   = (cnt_q == '0);
  assign cnt     = cnt_q;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign top_idx = cnt_q[PW-1:0] - IDX_ONE;
  assign top     = empty ? '0 : mem_q[top_idx];

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (do_push) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (do_pop) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // NOTE: storage is deliberately left unreset; the counter alone decides which entries are live.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem_q[cnt_q[PW-1:0]] <= din;
    end
  end

endmodule : ret_stack

// File: rtl/pc_seq.sv
// Program counter sequencer: increment, absolute/relative branch, call/return with sticky stack errors.
module pc_seq
  import sisc_pkg::*;
#(
  parameter int            AW       = 16,
  parameter int            DEPTH    = 8,
  parameter logic [AW-1:0] RST_ADDR = '0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   pc_rst,
  input  logic                   pc_write,
  input  logic [1:0]             pc_mode,
  input  logic                   br_sel,
  input  logic [AW-1:0]          imm,
  input  logic                   err_clr,
  output logic [AW-1:0]          pc_out,
  output logic [AW-1:0]          pc_inc,
  output logic [$clog2(DEPTH):0] stk_cnt,
  output logic                   stk_full,
  output logic                   stk_empty,
  output logic                   ovf_err,
  output logic                   unf_err
);

  localparam logic [AW-1:0] PC_ONE = AW'(1);

  pc_mode_e      mode;
  logic [AW-1:0] pc_q, pc_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          ovf_set, unf_set;
  logic          push, pop;
  logic [AW-1:0] stk_top;

  assign mode   = pc_mode_e'(pc_mode);
  assign pc_inc = pc_q + PC_ONE;
  assign pc_out = pc_q;

  ret_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .CLK   (CLK),
    .RST   (RST),
    .flush (pc_rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (stk_top),
    .cnt   (stk_cnt),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (pc_rst) begin
      pc_d = RST_ADDR;
    end else if (pc_write) begin
      case (mode)
        PCM_INC: pc_d = pc_inc;
        PCM_BR:  pc_d = br_sel ? (pc_inc + imm) : imm;
        PCM_CALL: begin
          if (stk_full) begin
            pc_d    = pc_inc;
            ovf_set = 1'b1;
          end else begin
            pc_d = imm;
            push = 1'b1;
          end
        end
        PCM_RET: begin
          if (stk_empty) begin
            pc_d    = pc_inc;
            unf_set = 1'b1;
          end else begin
            pc_d = stk_top;
            pop  = 1'b1;
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  // A new error raised on the same edge as err_clr wins over the clear.
  assign ovf_d = ovf_set | (ovf_q & ~err_clr);
  assign unf_d = unf_set | (unf_q & ~err_clr);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q  <= RST_ADDR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

endmodule : pc_seq

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed scenarios plus randomized traffic against a queue-based model.
module tb_pc_seq;

  localparam int            AW       = 16;
  localparam int            DEPTH    = 8;
  localparam logic [AW-1:0] RST_ADDR = '0;

  logic          CLK = 1'b0;
  logic          RST;
  logic          pc_rst, pc_write, br_sel, err_clr;
  logic [1:0]    pc_mode;
  logic [AW-1:0] imm;
  logic [AW-1:0] pc_out, pc_inc;
  logic [3:0]    stk_cnt;
  logic          stk_full, stk_empty, ovf_err, unf_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] pc_m;
  logic [AW-1:0] stk_m[$];
  logic          ovf_m, unf_m;

  pc_seq #(.AW(AW), .DEPTH(DEPTH), .RST_ADDR(RST_ADDR)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .pc_rst    (pc_rst),
    .pc_write  (pc_write),
    .pc_mode   (pc_mode),
    .br_sel    (br_sel),
    .imm       (imm),
    .err_clr   (err_clr),
    .pc_out    (pc_out),
    .pc_inc    (pc_inc),
    .stk_cnt   (stk_cnt),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .ovf_err   (ovf_err),
    .unf_err   (unf_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    pc_m  = RST_ADDR;
    stk_m.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
  endtask

  // One clock edge of behaviour, taken straight from the mode rules.
  task automatic model_edge();
    logic [AW-1:0] inc;
    logic          oset, uset;
    inc  = pc_m + 16'd1;
    oset = 1'b0;
    uset = 1'b0;
    if (pc_rst) begin
      pc_m = RST_ADDR;
      stk_m.delete();
    end else if (pc_write) begin
      if (pc_mode == 2'd0) pc_m = inc;
      else if (pc_mode == 2'd1) pc_m = br_sel ? inc + imm : imm;
      else if (pc_mode == 2'd2) begin
        if (stk_m.size() < DEPTH) begin
          stk_m.push_back(inc);
          pc_m = imm;
        end else begin
          pc_m = inc;
          oset = 1'b1;
        end
      end else begin
        if (stk_m.size() > 0) pc_m = stk_m.pop_back();
        else begin
          pc_m = inc;
          uset = 1'b1;
        end
      end
    end
    ovf_m = oset | (ovf_m & ~err_clr);
    unf_m = uset | (unf_m & ~err_clr);
  endtask

  task automatic check_all(input string tag);
    logic [AW-1:0] inc_m;
    inc_m = pc_m + 16'd1;
    check({tag, ".pc_out"},  32'(pc_out),    32'(pc_m));
    check({tag, ".pc_inc"},  32'(pc_inc),    32'(inc_m));
    check({tag, ".stk_cnt"}, 32'(stk_cnt),   32'(stk_m.size()));
    check({tag, ".full"},    32'(stk_full),  32'(stk_m.size() == DEPTH));
    check({tag, ".empty"},   32'(stk_empty), 32'(stk_m.size() == 0));
    check({tag, ".ovf"},     32'(ovf_err),   32'(ovf_m));
    check({tag, ".unf"},     32'(unf_err),   32'(unf_m));
  endtask

  // Drive one cycle's inputs away from the edge, advance the model, sample 1 ns after the edge.
  task automatic cyc(input string tag, input logic w, input logic [1:0] m, input logic bs,
                     input logic [AW-1:0] im, input logic ec, input logic fl);
    pc_write = w;
    pc_mode  = m;
    br_sel   = bs;
    imm      = im;
    err_clr  = ec;
    pc_rst   = fl;
    model_edge();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  initial begin
    RST = 1'b1;
    {pc_rst, pc_write, br_sel, err_clr} = '0;
    pc_mode = 2'd0;
    imm     = '0;
    model_reset();
    #2;
    check("rst.pc_out", 32'(pc_out), 32'(RST_ADDR));
    check("rst.stk_cnt", 32'(stk_cnt), 32'd0);
    check("rst.full_empty", {30'd0, stk_full, stk_empty}, 32'b01);
    check("rst.flags", {30'd0, ovf_err, unf_err}, 32'b00);
    @(negedge CLK);
    RST = 1'b0;

    // Reset then three increments.
    for (int i = 1; i <= 3; i++) begin
      cyc("inc", 1'b1, 2'd0, 1'b0, 16'h0, 1'b0, 1'b0);
      check("inc.abs", 32'(pc_out), 32'(i));
    end
    check("inc.empty", 32'(stk_empty), 32'd1);

    // Relative and absolute branch.
    cyc("br_set", 1'b1, 2'd1, 1'b0, 16'h0010, 1'b0, 1'b0);
    cyc("br_rel", 1'b1, 2'd1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    check("br_rel.abs", 32'(pc_out), 32'h000F);
    cyc("br_abs", 1'b1, 2'd1, 1'b0, 16'h0040, 1'b0, 1'b0);
    check("br_abs.abs", 32'(pc_out), 32'h0040);

    // Hold with no write.
    cyc("hold", 1'b0, 2'd2, 1'b0, 16'h1234, 1'b0, 1'b0);
    check("hold.abs", 32'(pc_out), 32'h0040);

    // Nested call/return.
    cyc("nest_set", 1'b1, 2'd1, 1'b0, 16'h0005, 1'b0, 1'b0);
    cyc("call1", 1'b1, 2'd2, 1'b0, 16'h0100, 1'b0, 1'b0);
    check("call1.abs", {pc_out, 12'd0, stk_cnt}, {16'h0100, 12'd0, 4'd1});
    cyc("call2", 1'b1, 2'd2, 1'b0, 16'h0200, 1'b0, 1'b0);
    check("call2.abs", {pc_out, 12'd0, stk_cnt}, {16'h0200, 12'd0, 4'd2});
    cyc("ret1", 1'b1, 2'd3, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("ret1.abs", {pc_out, 12'd0, stk_cnt}, {16'h0101, 12'd0, 4'd1});
    cyc("ret2", 1'b1, 2'd3, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("ret2.abs", {pc_out, 12'd0, stk_cnt}, {16'h0006, 12'd0, 4'd0});

    // Overflow on the ninth call, set-wins-over-clear, then clear.
    for (int i = 0; i < 9; i++) cyc("ovf_fill", 1'b1, 2'd2, 1'b0, 16'h0300 + 16'(i), 1'b0, 1'b0);
    check("ovf.pc", 32'(pc_out), 32'h0308);
    check("ovf.state", {28'd0, ovf_err, stk_cnt[3], stk_full, unf_err}, 32'b1110);
    cyc("ovf_setwins", 1'b1, 2'd2, 1'b0, 16'h0400, 1'b1, 1'b0);
    check("ovf_setwins.abs", 32'(ovf_err), 32'd1);
    cyc("ovf_clr", 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("ovf_clr.abs", 32'(ovf_err), 32'd0);
    for (int i = 0; i < 8; i++) cyc("drain", 1'b1, 2'd3, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Underflow, then a flush with three live entries.
    cyc("unf_set", 1'b1, 2'd1, 1'b0, 16'h0030, 1'b0, 1'b0);
    cyc("unf", 1'b1, 2'd3, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("unf.abs", {pc_out, 15'd0, unf_err}, {16'h0031, 15'd0, 1'b1});
    for (int i = 0; i < 3; i++) cyc("fl_fill", 1'b1, 2'd2, 1'b0, 16'h0500, 1'b0, 1'b0);
    check("fl_fill.cnt", 32'(stk_cnt), 32'd3);
    cyc("flush", 1'b1, 2'd2, 1'b0, 16'h0700, 1'b0, 1'b1);
    check("flush.abs", {pc_out, 11'd0, stk_cnt, unf_err}, {16'h0000, 11'd0, 4'd0, 1'b1});
    cyc("stale_ret", 1'b1, 2'd3, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Wrap, then asynchronous reset between edges.
    cyc("wrap_set", 1'b1, 2'd1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    cyc("wrap", 1'b1, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("wrap.abs", 32'(pc_out), 32'h0000);
    cyc("pre_arst", 1'b1, 2'd2, 1'b0, 16'h0077, 1'b0, 1'b0);
    cyc("pre_arst2", 1'b1, 2'd3, 1'b0, 16'h0000, 1'b0, 1'b0);
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    check_all("arst");
    @(negedge CLK);
    RST = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [1:0] m;
      int r;
      r = $urandom_range(0, 99);
      m = (r < 30) ? 2'd0 : (r < 45) ? 2'd1 : (r < 75) ? 2'd2 : 2'd3;
      cyc("rand", ($urandom_range(0, 9) != 0), m, 1'($urandom), 16'($urandom),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pc_seq
